// File: rtl/lsu_mem_stage.sv
// Memory-access stage between EXU and WBU: one AXI4-Lite read or write per instruction,
// with store lane alignment, load extension and misaligned/bus-error exception reporting.
module lsu_mem_stage #(
  parameter logic [3:0] LD_MIS_CAUSE = 4'd4,
  parameter logic [3:0] LD_ERR_CAUSE = 4'd5,
  parameter logic [3:0] ST_MIS_CAUSE = 4'd6,
  parameter logic [3:0] ST_ERR_CAUSE = 4'd7
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_mem_ren,
  input  logic        i_mem_wen,
  input  logic [2:0]  i_mem_read_t,
  input  logic [3:0]  i_mem_wmask,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  input  logic [31:0] i_result,
  input  logic [4:0]  i_reg_rd,
  input  logic        i_reg_wen,
  input  logic [31:0] i_pc,
  input  logic        i_exception,
  input  logic [3:0]  i_mcause,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic [4:0]  o_reg_rd,
  output logic        o_reg_wen,
  output logic [31:0] o_pc,
  output logic        o_exception,
  output logic [3:0]  o_mcause,
  output logic [31:0] o_araddr,
  output logic        o_arvalid,
  input  logic        i_arready,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rresp,
  input  logic        i_rvalid,
  output logic        o_rready,
  output logic [31:0] o_awaddr,
  output logic        o_awvalid,
  input  logic        i_awready,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic        o_wvalid,
  input  logic        i_wready,
  input  logic [1:0]  i_bresp,
  input  logic        i_bvalid,
  output logic        o_bready
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRaddr = 3'd1;
  localparam logic [2:0] StRdata = 3'd2;
  localparam logic [2:0] StWreq  = 3'd3;
  localparam logic [2:0] StWresp = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [2:0]  read_t_q, read_t_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  rd_q, rd_d;
  logic        reg_wen_q, reg_wen_d;
  logic [31:0] pc_q, pc_d;
  logic        exc_q, exc_d;
  logic [3:0]  mcause_q, mcause_d;
  logic        valid_q, valid_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        bready_q, bready_d;

  logic        accept;
  logic        ld_mis;
  logic        st_mis;
  logic [31:0] rshift;
  logic [31:0] load_val;

  assign o_ready = (state_q == StIdle) | ((state_q == StDone) & i_ready);
  assign accept  = i_valid & o_ready;

  assign ld_mis = i_mem_ren & (((i_mem_read_t[1:0] == 2'b01) & i_mem_addr[0]) |
                               ((i_mem_read_t[1:0] == 2'b10) & (|i_mem_addr[1:0])));
  assign st_mis = i_mem_wen & (((i_mem_wmask == 4'b0011) & i_mem_addr[0]) |
                               ((i_mem_wmask == 4'b1111) & (|i_mem_addr[1:0])));

  assign rshift = i_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_val = rshift;
    case (read_t_q)
      3'b000:  load_val = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  load_val = {{16{rshift[15]}}, rshift[15:0]};
      3'b100:  load_val = {24'd0, rshift[7:0]};
      3'b101:  load_val = {16'd0, rshift[15:0]};
      default: load_val = rshift;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    read_t_d  = read_t_q;
    addr_d    = addr_q;
    result_d  = result_q;
    rd_d      = rd_q;
    reg_wen_d = reg_wen_q;
    pc_d      = pc_q;
    exc_d     = exc_q;
    mcause_d  = mcause_q;
    valid_d   = valid_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bready_d  = bready_q;

    case (state_q)
      StRaddr: begin
        if (i_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdata;
        end
      end
      StRdata: begin
        if (i_rvalid) begin
          rready_d = 1'b0;
          valid_d  = 1'b1;
          state_d  = StDone;
          if (i_rresp != 2'b00) begin
            exc_d    = 1'b1;
            mcause_d = LD_ERR_CAUSE;
            result_d = 32'd0;
          end else begin
            result_d = load_val;
          end
        end
      end
      StWreq: begin
        // AW and W complete independently; move on once neither is outstanding.
        if (i_awready) awvalid_d = 1'b0;
        if (i_wready) wvalid_d = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = StWresp;
        end
      end
      StWresp: begin
        if (i_bvalid) begin
          bready_d = 1'b0;
          valid_d  = 1'b1;
          state_d  = StDone;
          if (i_bresp != 2'b00) begin
            exc_d    = 1'b1;
            mcause_d = ST_ERR_CAUSE;
          end
        end
      end
      StDone: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: ;
    endcase

    // A new accept in DONE overrides the retire above.
    if (accept) begin
      addr_d    = i_mem_addr;
      read_t_d  = i_mem_read_t;
      rd_d      = i_reg_rd;
      reg_wen_d = i_reg_wen;
      pc_d      = i_pc;
      result_d  = i_result;
      exc_d     = 1'b0;
      mcause_d  = 4'd0;
      valid_d   = 1'b0;
      if (i_exception) begin
        exc_d    = 1'b1;
        mcause_d = i_mcause;
        valid_d  = 1'b1;
        state_d  = StDone;
      end else if (ld_mis || st_mis) begin
        exc_d    = 1'b1;
        mcause_d = i_mem_ren ? LD_MIS_CAUSE : ST_MIS_CAUSE;
        valid_d  = 1'b1;
        state_d  = StDone;
      end else if (i_mem_ren) begin
        arvalid_d = 1'b1;
        state_d   = StRaddr;
      end else if (i_mem_wen) begin
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        wdata_d   = i_mem_wdata << {i_mem_addr[1:0], 3'b000};
        wstrb_d   = i_mem_wmask << i_mem_addr[1:0];
        state_d   = StWreq;
      end else begin
        valid_d = 1'b1;
        state_d = StDone;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= StIdle;
      read_t_q  <= 3'd0;
      addr_q    <= 32'd0;
      result_q  <= 32'd0;
      rd_q      <= 5'd0;
      reg_wen_q <= 1'b0;
      pc_q      <= 32'd0;
      exc_q     <= 1'b0;
      mcause_q  <= 4'd0;
      valid_q   <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      bready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      read_t_q  <= read_t_d;
      addr_q    <= addr_d;
      result_q  <= result_d;
      rd_q      <= rd_d;
      reg_wen_q <= reg_wen_d;
      pc_q      <= pc_d;
      exc_q     <= exc_d;
      mcause_q  <= mcause_d;
      valid_q   <= valid_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bready_q  <= bready_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_result    = result_q;
  assign o_reg_rd    = rd_q;
  assign o_reg_wen   = reg_wen_q & ~exc_q;
  assign o_pc        = pc_q;
  assign o_exception = exc_q;
  assign o_mcause    = mcause_q;
  assign o_araddr    = addr_q;
  assign o_arvalid   = arvalid_q;
  assign o_rready    = rready_q;
  assign o_awaddr    = addr_q;
  assign o_awvalid   = awvalid_q;
  assign o_wdata     = wdata_q;
  assign o_wstrb     = wstrb_q;
  assign o_wvalid    = wvalid_q;
  assign o_bready    = bready_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: directed cases plus randomized instructions against a byte-level
// reference model, with a randomly stalling AXI-Lite slave.
module tb_lsu_mem_stage;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_valid, o_ready;
  logic        i_mem_ren, i_mem_wen;
  logic [2:0]  i_mem_read_t;
  logic [3:0]  i_mem_wmask;
  logic [31:0] i_mem_addr, i_mem_wdata, i_result;
  logic [4:0]  i_reg_rd;
  logic        i_reg_wen;
  logic [31:0] i_pc;
  logic        i_exception;
  logic [3:0]  i_mcause;
  logic        o_valid, i_ready;
  logic [31:0] o_result;
  logic [4:0]  o_reg_rd;
  logic        o_reg_wen;
  logic [31:0] o_pc;
  logic        o_exception;
  logic [3:0]  o_mcause;
  logic [31:0] o_araddr;
  logic        o_arvalid, i_arready;
  logic [31:0] i_rdata;
  logic [1:0]  i_rresp;
  logic        i_rvalid, o_rready;
  logic [31:0] o_awaddr;
  logic        o_awvalid, i_awready;
  logic [31:0] o_wdata;
  logic [3:0]  o_wstrb;
  logic        o_wvalid, i_wready;
  logic [1:0]  i_bresp;
  logic        i_bvalid, o_bready;

  always #5 i_clock = ~i_clock;

  lsu_mem_stage dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_mem_ren(i_mem_ren), .i_mem_wen(i_mem_wen), .i_mem_read_t(i_mem_read_t),
    .i_mem_wmask(i_mem_wmask), .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata),
    .i_result(i_result), .i_reg_rd(i_reg_rd), .i_reg_wen(i_reg_wen), .i_pc(i_pc),
    .i_exception(i_exception), .i_mcause(i_mcause), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_reg_rd(o_reg_rd), .o_reg_wen(o_reg_wen), .o_pc(o_pc),
    .o_exception(o_exception), .o_mcause(o_mcause), .o_araddr(o_araddr),
    .o_arvalid(o_arvalid), .i_arready(i_arready), .i_rdata(i_rdata), .i_rresp(i_rresp),
    .i_rvalid(i_rvalid), .o_rready(o_rready), .o_awaddr(o_awaddr), .o_awvalid(o_awvalid),
    .i_awready(i_awready), .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid),
    .i_wready(i_wready), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clock);
    #1;
  endtask

  // Slave configuration, written only by the main sequence
  bit          zero_wait = 1'b0;
  int          w_hold = 0;
  bit          hold_r = 1'b0;
  bit          fix_en = 1'b0;
  logic [31:0] fix_rdata = 32'd0;
  logic [1:0]  fix_rresp = 2'd0;
  logic [1:0]  fix_bresp = 2'd0;

  // Handshake monitor
  int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, proto_err;
  logic [31:0] ar_addr, aw_addr, w_data, ar_paddr, aw_paddr, w_pdata;
  logic [3:0]  w_strb, w_pstrb;
  bit          ar_pend, aw_pend, w_pend;

  always @(posedge i_clock) begin
    if (i_reset) begin
      ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; proto_err <= 0;
      ar_pend <= 1'b0; aw_pend <= 1'b0; w_pend <= 1'b0;
    end else begin
      // An offered request must stay put until it is taken
      proto_err <= proto_err + int'(ar_pend && !(o_arvalid && o_araddr == ar_paddr))
                 + int'(aw_pend && !(o_awvalid && o_awaddr == aw_paddr))
                 + int'(w_pend && !(o_wvalid && o_wdata == w_pdata && o_wstrb == w_pstrb));
      ar_pend <= o_arvalid && !i_arready; ar_paddr <= o_araddr;
      aw_pend <= o_awvalid && !i_awready; aw_paddr <= o_awaddr;
      w_pend <= o_wvalid && !i_wready; w_pdata <= o_wdata; w_pstrb <= o_wstrb;
      if (o_arvalid && i_arready) begin ar_cnt <= ar_cnt + 1; ar_addr <= o_araddr; end
      if (o_awvalid && i_awready) begin aw_cnt <= aw_cnt + 1; aw_addr <= o_awaddr; end
      if (o_wvalid && i_wready) begin
        w_cnt <= w_cnt + 1; w_data <= o_wdata; w_strb <= o_wstrb;
      end
      if (o_rready && i_rvalid) r_cnt <= r_cnt + 1;
      if (o_bready && i_bvalid) b_cnt <= b_cnt + 1;
    end
  end

  // Slave responder
  int r_sent, b_sent, w_age;

  always @(negedge i_clock) begin
    if (i_reset) begin
      i_arready <= 1'b0; i_awready <= 1'b0; i_wready <= 1'b0;
      i_rvalid <= 1'b0; i_bvalid <= 1'b0; i_rdata <= 32'd0; i_rresp <= 2'd0; i_bresp <= 2'd0;
      r_sent <= 0; b_sent <= 0; w_age <= 0;
    end else begin
      i_arready <= zero_wait ? 1'b1 : 1'($urandom % 2);
      i_awready <= zero_wait ? 1'b1 : 1'($urandom % 2);
      i_wready <= zero_wait ? (w_age >= w_hold) : 1'($urandom % 2);
      w_age <= o_wvalid ? w_age + 1 : 0;
      if (i_rvalid) begin
        if (r_cnt == r_sent) i_rvalid <= 1'b0;
      end else if (ar_cnt > r_sent && !hold_r && (zero_wait || $urandom % 3 == 0)) begin
        i_rvalid <= 1'b1;
        i_rdata <= fix_en ? fix_rdata : $urandom;
        i_rresp <= fix_en ? fix_rresp : (($urandom % 5 == 0) ? 2'($urandom_range(1, 3)) : 2'd0);
        r_sent <= r_sent + 1;
      end
      if (i_bvalid) begin
        if (b_cnt == b_sent) i_bvalid <= 1'b0;
      end else if (aw_cnt > b_sent && w_cnt > b_sent && (zero_wait || $urandom % 3 == 0)) begin
        i_bvalid <= 1'b1;
        i_bresp <= fix_en ? fix_bresp : (($urandom % 5 == 0) ? 2'($urandom_range(1, 3)) : 2'd0);
        b_sent <= b_sent + 1;
      end
    end
  end

  task automatic drive(input bit exc_in, input logic [3:0] mc_in, input bit ren, input bit wen,
                       input logic [2:0] rt, input logic [3:0] wm, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] res, input logic [4:0] rd,
                       input bit rwen, input logic [31:0] pc);
    i_exception = exc_in; i_mcause = mc_in; i_mem_ren = ren; i_mem_wen = wen;
    i_mem_read_t = rt; i_mem_wmask = wm; i_mem_addr = addr; i_mem_wdata = wd;
    i_result = res; i_reg_rd = rd; i_reg_wen = rwen; i_pc = pc;
  endtask

  // Issue one instruction, let it complete, compare with the model, then retire it
  task automatic run(input bit exc_in, input logic [3:0] mc_in, input bit ren, input bit wen,
                     input logic [2:0] rt, input logic [3:0] wm, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] res, input logic [4:0] rd,
                     input bit rwen, input int bp);
    int ar0, r0, aw0, w0, b0, lat, size, off, exp_lat;
    bit mis, mem, go, exp_exc;
    logic [3:0] exp_cause, exp_strb;
    logic [31:0] exp_res, val, exp_wd, pc, s_res, s_pc;
    logic [12:0] s_ctl;
    ar0 = ar_cnt; r0 = r_cnt; aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    pc = $urandom;
    size = ren ? ((rt[1:0] == 2'd0) ? 1 : (rt[1:0] == 2'd1) ? 2 : 4)
               : ((wm == 4'b0001) ? 1 : (wm == 4'b0011) ? 2 : 4);
    off = int'(addr[1:0]);
    mem = ren | wen;
    mis = mem && (off % size != 0);
    go = mem && !exc_in && !mis;
    drive(exc_in, mc_in, ren, wen, rt, wm, addr, wd, res, rd, rwen, pc);
    i_valid = 1'b1;
    i_ready = 1'b0;
    check("ready_idle", o_ready, 1);
    tick();
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 80) begin
      tick();
      lat++;
    end
    check("o_valid", o_valid, 1);
    exp_lat = go ? ((zero_wait && w_hold == 0) ? 3 : -1) : 1;
    if (exp_lat > 0) check("latency", lat, exp_lat);

    exp_exc = 1'b0; exp_cause = 4'd0; exp_res = res;
    if (exc_in) begin
      exp_exc = 1'b1; exp_cause = mc_in;
    end else if (mis) begin
      exp_exc = 1'b1; exp_cause = ren ? 4'd4 : 4'd6;
    end else if (ren) begin
      val = 32'd0;
      for (int i = 0; i < size; i++) val[8*i +: 8] = i_rdata[8*(off+i) +: 8];
      if (!rt[2]) for (int i = size; i < 4; i++) val[8*i +: 8] = {8{val[8*size-1]}};
      if (i_rresp != 2'd0) begin
        exp_exc = 1'b1; exp_cause = 4'd5; exp_res = 32'd0;
      end else begin
        exp_res = val;
      end
    end else if (wen && i_bresp != 2'd0) begin
      exp_exc = 1'b1; exp_cause = 4'd7;
    end
    check("exception", o_exception, exp_exc);
    if (exp_exc) check("mcause", o_mcause, exp_cause);
    if (!wen && !exc_in && !mis) check("result", o_result, exp_res);
    check("reg_rd", o_reg_rd, rd);
    check("pc", o_pc, pc);
    check("reg_wen", o_reg_wen, rwen && !exp_exc);
    check("ar_count", ar_cnt - ar0, go && ren);
    check("r_count", r_cnt - r0, go && ren);
    check("aw_count", aw_cnt - aw0, go && wen);
    check("w_count", w_cnt - w0, go && wen);
    check("b_count", b_cnt - b0, go && wen);
    if (go && ren) check("araddr", ar_addr, addr);
    if (go && wen) begin
      exp_wd = 32'd0;
      exp_strb = 4'd0;
      for (int i = off; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i-off) +: 8];
      for (int i = 0; i < size; i++) exp_strb[off+i] = 1'b1;
      check("awaddr", aw_addr, addr);
      check("wdata", w_data, exp_wd);
      check("wstrb", w_strb, exp_strb);
    end

    check("ready_bp", o_ready, 0);
    s_res = o_result; s_pc = o_pc;
    s_ctl = {o_valid, o_ready, o_exception, o_mcause, o_reg_wen, o_reg_rd};
    repeat (bp) begin
      tick();
      check("hold_ctl", {o_valid, o_ready, o_exception, o_mcause, o_reg_wen, o_reg_rd}, s_ctl);
      check("hold_result", o_result, s_res);
      check("hold_pc", o_pc, s_pc);
    end
    i_ready = 1'b1;
    #1;
    check("ready_done", o_ready, 1);
    tick();
    i_ready = 1'b0;
    check("retire", o_valid, 0);
  endtask

  logic [2:0] rts [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  logic [3:0] wms [3] = '{4'b0001, 4'b0011, 4'b1111};

  initial begin
    int lat;
    i_reset = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    drive(0, 4'd0, 0, 0, 3'd0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0, 0, 32'd0);
    tick();
    tick();
    check("rst_handshakes", {o_valid, o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready}, 0);
    check("rst_result", o_result, 0);
    check("rst_ready", o_ready, 1);
    i_reset = 1'b0;
    tick();

    // Directed cases with a zero-wait slave and fixed responses
    zero_wait = 1'b1; fix_en = 1'b1; fix_rdata = 32'h80FF0000;
    run(0, 4'd0, 0, 0, 3'b000, 4'd0, 32'h0, 32'h0, 32'h00001234, 5'd5, 1, 3);
    run(0, 4'd0, 1, 0, 3'b000, 4'd0, 32'h80000003, 32'h0, 32'h0, 5'd7, 1, 0);
    run(0, 4'd0, 1, 0, 3'b100, 4'd0, 32'h80000003, 32'h0, 32'h0, 5'd8, 1, 1);
    run(0, 4'd0, 1, 0, 3'b001, 4'd0, 32'h80000002, 32'h0, 32'h0, 5'd9, 1, 0);
    w_hold = 2;
    run(0, 4'd0, 0, 1, 3'b000, 4'b0011, 32'h80000002, 32'h0000BEEF, 32'h0, 5'd0, 0, 0);
    w_hold = 0;
    run(0, 4'd0, 1, 0, 3'b010, 4'd0, 32'h80000001, 32'h0, 32'h0, 5'd3, 1, 0);
    run(0, 4'd0, 0, 1, 3'b000, 4'b1111, 32'h80000002, 32'h12345678, 32'h0, 5'd0, 0, 0);
    fix_rresp = 2'b10;
    run(0, 4'd0, 1, 0, 3'b010, 4'd0, 32'h80000004, 32'h0, 32'h0, 5'd4, 1, 2);
    fix_rresp = 2'b00; fix_bresp = 2'b11;
    run(0, 4'd0, 0, 1, 3'b000, 4'b1111, 32'h80000008, 32'hCAFEF00D, 32'h0, 5'd0, 0, 0);
    fix_bresp = 2'b00;
    run(1, 4'd2, 1, 0, 3'b010, 4'd0, 32'h80000010, 32'h0, 32'h0, 5'd6, 1, 0);

    // Back-to-back: accept the next instruction in the cycle the current one retires
    drive(0, 4'd0, 0, 0, 3'd0, 4'd0, 32'd0, 32'd0, 32'hAAAA0001, 5'd1, 1, 32'h100);
    i_valid = 1'b1;
    tick();
    check("b2b_first", o_result, 32'hAAAA0001);
    drive(0, 4'd0, 0, 0, 3'd0, 4'd0, 32'd0, 32'd0, 32'hAAAA0002, 5'd2, 1, 32'h104);
    i_ready = 1'b1;
    #1;
    check("b2b_ready", o_ready, 1);
    tick();
    i_valid = 1'b0; i_ready = 1'b0;
    check("b2b_valid", o_valid, 1);
    check("b2b_second", o_result, 32'hAAAA0002);
    check("b2b_rd", o_reg_rd, 2);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check("b2b_retire", o_valid, 0);

    // Randomized instructions against a stalling slave
    fix_en = 1'b0;
    for (int n = 0; n < 150; n++) begin
      int k;
      bit ren, wen;
      logic [31:0] a;
      k = int'($urandom % 10);
      ren = (k >= 3 && k <= 6) || (k == 0 && $urandom % 2 == 0);
      wen = (k >= 7) || (k == 0 && !ren && $urandom % 2 == 0);
      a = $urandom;
      if ($urandom % 2 == 0) a[1:0] = 2'b00;
      zero_wait = ($urandom % 4 == 0);
      run(k == 0, 4'($urandom), ren, wen, rts[$urandom % 5], wms[$urandom % 3], a, $urandom,
          $urandom, 5'($urandom), 1'($urandom), int'($urandom % 4));
    end
    check("axi_stable", proto_err, 0);

    // Reset while waiting for read data abandons the load
    zero_wait = 1'b1; hold_r = 1'b1;
    drive(0, 4'd0, 1, 0, 3'b010, 4'd0, 32'h80000010, 32'd0, 32'd0, 5'd1, 1, 32'h200);
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    lat = 0;
    while (!o_rready && lat < 20) begin
      tick();
      lat++;
    end
    check("reach_rdata", o_rready, 1);
    i_reset = 1'b1;
    #1;
    check("rst_mid_rready", o_rready, 0);
    check("rst_mid_valid", o_valid, 0);
    check("rst_mid_ready", o_ready, 1);
    tick();
    tick();
    i_reset = 1'b0; hold_r = 1'b0;
    tick();
    run(0, 4'd0, 0, 0, 3'b000, 4'd0, 32'h0, 32'h0, 32'h0BADF00D, 5'd31, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
